uart_tx_sequencer: RTL and testbench

Serial transmit engine for the UART Tx path. It consumes the level-held TxDataReady/TxData pair produced by the Tx FIFO controller and serializes each byte onto TXD as start, data, optional parity and stop bits. It reports TxBusy and a stretched TxDone so the FIFO controller can synchronize both, detect the TxDone edge, and present the next byte. It sits between the Tx FIFO controller and the pad, in the DSP_CLK domain.

---
 rtl/uart_tx_pkg.sv | 31 +++
 rtl/uart_baud_gen.sv | 30 +++
 rtl/uart_tx_sequencer.sv | 144 ++++++++++++++
 tb/tb_uart_tx_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5
  } tx_state_e;

  localparam logic [1:0] DB5 = 2'b00;
  localparam logic [1:0] DB6 = 2'b01;
  localparam logic [1:0] DB7 = 2'b10;
  localparam logic [1:0] DB8 = 2'b11;

  localparam int MIN_DIV = 2;

  // Index of the last data bit (N-1) for a DataBits code.
  function automatic logic [2:0] last_bit_idx(input logic [1:0] db);
    case (db)
      DB5:     return 3'd4;
      DB6:     return 3'd5;
      DB7:     return 3'd6;
      DB8:     return 3'd7;
      default: return 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period down-counter: loads Div-1, ticks on reaching 0 and reloads itself.
module uart_baud_gen
  import uart_tx_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             bit_tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign bit_tick_o = en_i && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i || bit_tick_o) cnt_d = div_i - DIV_W'(1);
    else if (en_i)            cnt_d = cnt_q - DIV_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_sequencer.sv
// UART transmit FSM: serializes a latched byte as start, data, parity, stop,
// then holds TxDone so the FIFO controller can observe the frame end.
module uart_tx_sequencer
  import uart_tx_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int DONE_CYCLES = 4
) (
  input  logic             DSP_CLK,
  input  logic             RESET,
  input  logic             TxEn,
  input  logic [DIV_W-1:0] BaudDiv,
  input  logic [1:0]       DataBits,
  input  logic             ParityEn,
  input  logic             ParityOdd,
  input  logic             StopBits2,
  input  logic             TxDataReady,
  input  logic [7:0]       TxData,
  output logic             TxBusy,
  output logic             TxDone,
  output logic             TXD,
  output logic [2:0]       TxState
);

  // One counter serves data bits remaining, stop bits remaining and DONE hold.
  localparam int CNT_W = ($clog2(DONE_CYCLES) > 3) ? $clog2(DONE_CYCLES) : 3;

  tx_state_e        state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       nlast_q, nlast_d;
  logic             par_q, par_d;
  logic             pe_q, pe_d;
  logic             s2_q, s2_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] eff_div, gen_div;
  logic             load, tick, baud_en;

  assign eff_div = (BaudDiv < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : BaudDiv;
  // The latch edge loads straight from the input; later reloads use the latched copy.
  assign gen_div = (state_q == ST_IDLE) ? eff_div : div_q;
  assign baud_en = (state_q == ST_START) || (state_q == ST_DATA) ||
                   (state_q == ST_PARITY) || (state_q == ST_STOP);

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk_i      (DSP_CLK),
    .rst_i      (RESET),
    .load_i     (load),
    .en_i       (baud_en),
    .div_i      (gen_div),
    .bit_tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    nlast_d = nlast_q;
    par_d   = par_q;
    pe_d    = pe_q;
    s2_d    = s2_q;
    div_d   = div_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: if (TxEn && TxDataReady) begin
        state_d = ST_START;
        shift_d = TxData;
        nlast_d = last_bit_idx(DataBits);
        par_d   = ParityOdd;
        pe_d    = ParityEn;
        s2_d    = StopBits2;
        div_d   = eff_div;
        load    = 1'b1;
      end
      ST_START: if (tick) begin
        state_d = ST_DATA;
        cnt_d   = CNT_W'(nlast_q);
      end
      ST_DATA: if (tick) begin
        par_d   = par_q ^ shift_q[0];
        shift_d = {1'b0, shift_q[7:1]};
        if (cnt_q == '0) begin
          if (pe_q) state_d = ST_PARITY;
          else begin
            state_d = ST_STOP;
            cnt_d   = CNT_W'(s2_q);
          end
        end else cnt_d = cnt_q - CNT_W'(1);
      end
      ST_PARITY: if (tick) begin
        state_d = ST_STOP;
        cnt_d   = CNT_W'(s2_q);
      end
      ST_STOP: if (tick) begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          cnt_d   = CNT_W'(DONE_CYCLES - 1);
        end else cnt_d = cnt_q - CNT_W'(1);
      end
      ST_DONE: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge DSP_CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      nlast_q <= '0;
      par_q   <= 1'b0;
      pe_q    <= 1'b0;
      s2_q    <= 1'b0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      nlast_q <= nlast_d;
      par_q   <= par_d;
      pe_q    <= pe_d;
      s2_q    <= s2_d;
      div_q   <= div_d;
    end
  end

  always_comb begin
    TXD = 1'b1;
    case (state_q)
      ST_START:  TXD = 1'b0;
      ST_DATA:   TXD = shift_q[0];
      ST_PARITY: TXD = par_q;
      default:   TXD = 1'b1;
    endcase
  end

  assign TxBusy  = (state_q != ST_IDLE);
  assign TxDone  = (state_q == ST_DONE);
  assign TxState = state_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Bench for uart_tx_sequencer: per-cycle frame waveform predicted from the
// frame rules (bit list x Div, then DONE hold) and compared cycle by cycle.
module tb_uart_tx_sequencer;

  localparam int DIV_W = 16;
  localparam int DONE_CYCLES = 4;

  logic             DSP_CLK = 1'b0;
  logic             RESET;
  logic             TxEn;
  logic [DIV_W-1:0] BaudDiv;
  logic [1:0]       DataBits;
  logic             ParityEn, ParityOdd, StopBits2;
  logic             TxDataReady;
  logic [7:0]       TxData;
  logic             TxBusy, TxDone, TXD;
  logic [2:0]       TxState;

  int checks = 0;
  int errors = 0;

  logic exp_txd[$];
  logic exp_done[$];
  int   exp_st[$];

  uart_tx_sequencer #(.DIV_W(DIV_W), .DONE_CYCLES(DONE_CYCLES)) dut (
    .DSP_CLK     (DSP_CLK),
    .RESET       (RESET),
    .TxEn        (TxEn),
    .BaudDiv     (BaudDiv),
    .DataBits    (DataBits),
    .ParityEn    (ParityEn),
    .ParityOdd   (ParityOdd),
    .StopBits2   (StopBits2),
    .TxDataReady (TxDataReady),
    .TxData      (TxData),
    .TxBusy      (TxBusy),
    .TxDone      (TxDone),
    .TXD         (TXD),
    .TxState     (TxState)
  );

  always #5 DSP_CLK = ~DSP_CLK;

  task automatic tick();
    @(posedge DSP_CLK);
    #1;
  endtask

  // Expected line per cycle, starting the cycle after the IDLE sample.
  task automatic build_frame(input int div, input int db, input bit pe, input bit po,
                             input bit s2, input logic [7:0] d);
    logic b[$];
    int   st[$];
    int   n, dv;
    logic p;
    n  = db + 5;
    dv = (div < 2) ? 2 : div;
    exp_txd.delete(); exp_done.delete(); exp_st.delete();
    b.push_back(1'b0); st.push_back(1);
    p = po;
    for (int k = 0; k < n; k++) begin
      b.push_back(d[k]); st.push_back(2);
      p = p ^ d[k];
    end
    if (pe) begin b.push_back(p); st.push_back(3); end
    b.push_back(1'b1); st.push_back(4);
    if (s2) begin b.push_back(1'b1); st.push_back(4); end
    for (int k = 0; k < b.size(); k++)
      repeat (dv) begin
        exp_txd.push_back(b[k]); exp_done.push_back(1'b0); exp_st.push_back(st[k]);
      end
    repeat (DONE_CYCLES) begin
      exp_txd.push_back(1'b1); exp_done.push_back(1'b1); exp_st.push_back(5);
    end
  endtask

  // Called one cycle after the sample edge; returns in the first IDLE cycle.
  task automatic expect_frame(input string nm, input int upd, input int txen_off);
    int first_done;
    first_done = -1;
    for (int i = 0; i < exp_txd.size(); i++) begin
      checks++;
      if (TXD !== exp_txd[i]) begin
        errors++;
        $display("FAIL %s txd cyc %0d got %b exp %b", nm, i + 1, TXD, exp_txd[i]);
      end
      checks++;
      if (TxBusy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy cyc %0d got %b exp 1", nm, i + 1, TxBusy);
      end
      checks++;
      if (TxDone !== exp_done[i]) begin
        errors++;
        $display("FAIL %s done cyc %0d got %b exp %b", nm, i + 1, TxDone, exp_done[i]);
      end
      checks++;
      if (int'(TxState) != exp_st[i]) begin
        errors++;
        $display("FAIL %s state cyc %0d got %0d exp %0d", nm, i + 1, TxState, exp_st[i]);
      end
      if (exp_done[i] && first_done < 0) first_done = i;
      if (upd >= 0 && first_done >= 0 && i == first_done + 2) TxData = upd[7:0];
      if (i == txen_off) TxEn = 1'b0;
      tick();
    end
  endtask

  task automatic check_idle(input string nm);
    checks++;
    if (TxState !== 3'd0 || TxBusy !== 1'b0 || TxDone !== 1'b0 || TXD !== 1'b1) begin
      errors++;
      $display("FAIL %s idle got st=%0d busy=%b done=%b txd=%b exp st=0 busy=0 done=0 txd=1",
               nm, TxState, TxBusy, TxDone, TXD);
    end
  endtask

  task automatic scramble_cfg();
    BaudDiv   = DIV_W'($urandom_range(0, 9));
    DataBits  = 2'($urandom_range(0, 3));
    ParityEn  = 1'($urandom);
    ParityOdd = 1'($urandom);
    StopBits2 = 1'($urandom);
    TxData    = 8'($urandom);
  endtask

  // Single frame; config and data are scrambled after the latch edge.
  task automatic run_frame(input string nm, input int div, input int db, input bit pe,
                           input bit po, input bit s2, input logic [7:0] d);
    BaudDiv = DIV_W'(div); DataBits = 2'(db); ParityEn = pe; ParityOdd = po;
    StopBits2 = s2; TxData = d; TxEn = 1'b1; TxDataReady = 1'b1;
    build_frame(div, db, pe, po, s2, d);
    tick();
    TxDataReady = 1'b0;
    scramble_cfg();
    expect_frame(nm, -1, -1);
    check_idle(nm);
  endtask

  task automatic test_reset();
    RESET = 1'b1; TxEn = 1'b0; TxDataReady = 1'b0; BaudDiv = '0; DataBits = '0;
    ParityEn = 1'b0; ParityOdd = 1'b0; StopBits2 = 1'b0; TxData = '0;
    repeat (3) tick();
    check_idle("reset_held");
    RESET = 1'b0;
    repeat (2) tick();
    check_idle("reset_released");
  endtask

  task automatic test_directed();
    run_frame("8N1_A5", 4, 3, 1'b0, 1'b0, 1'b0, 8'hA5);
    run_frame("7E2_55", 3, 2, 1'b1, 1'b0, 1'b1, 8'h55);
    run_frame("5O1_FF_div0", 0, 0, 1'b1, 1'b1, 1'b0, 8'hFF);
    run_frame("6N1_div1", 1, 1, 1'b0, 1'b0, 1'b0, 8'hC3);
  endtask

  task automatic test_random();
    for (int r = 0; r < 10; r++)
      run_frame($sformatf("rand%0d", r), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
  endtask

  task automatic test_back_to_back();
    BaudDiv = 16'd3; DataBits = 2'd3; ParityEn = 1'b1; ParityOdd = 1'b0; StopBits2 = 1'b0;
    TxData = 8'h11; TxEn = 1'b1; TxDataReady = 1'b1;
    build_frame(3, 3, 1'b1, 1'b0, 1'b0, 8'h11);
    tick();
    expect_frame("b2b_first", 'h22, -1);
    check_idle("b2b_gap");
    build_frame(3, 3, 1'b1, 1'b0, 1'b0, 8'h22);
    tick();
    TxDataReady = 1'b0;
    expect_frame("b2b_second", -1, -1);
    check_idle("b2b_end");
  endtask

  task automatic test_txen_off();
    BaudDiv = 16'd3; DataBits = 2'd3; ParityEn = 1'b0; ParityOdd = 1'b0; StopBits2 = 1'b0;
    TxData = 8'h3C; TxEn = 1'b1; TxDataReady = 1'b1;
    build_frame(3, 3, 1'b0, 1'b0, 1'b0, 8'h3C);
    tick();
    expect_frame("txen_off", -1, 7);
    for (int i = 0; i < 12; i++) begin
      check_idle("txen_off_hold");
      tick();
    end
    TxDataReady = 1'b0;
    TxEn = 1'b1;
  endtask

  task automatic test_reset_mid();
    BaudDiv = 16'd4; DataBits = 2'd3; ParityEn = 1'b0; ParityOdd = 1'b0; StopBits2 = 1'b0;
    TxData = 8'hA5; TxEn = 1'b1; TxDataReady = 1'b1;
    build_frame(4, 3, 1'b0, 1'b0, 1'b0, 8'hA5);
    tick();
    TxDataReady = 1'b0;
    repeat (17) tick();
    checks++;
    if (TxState !== 3'd2 || TXD !== exp_txd[17]) begin
      errors++;
      $display("FAIL rst_mid pre st=%0d txd=%b exp st=2 txd=%b", TxState, TXD, exp_txd[17]);
    end
    RESET = 1'b1;
    #1;
    check_idle("rst_mid_async");
    TxData = 8'h96; TxDataReady = 1'b1;
    #1;
    RESET = 1'b0;
    build_frame(4, 3, 1'b0, 1'b0, 1'b0, 8'h96);
    tick();
    TxDataReady = 1'b0;
    expect_frame("rst_mid_fresh", -1, -1);
    check_idle("rst_mid_end");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_txen_off();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
